// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / load-store) arbiter onto one shared memory port, with ack timeout.
// Optional tie-break fairness: define MEM_ARB_ROUND_ROBIN_EN (default: data side always wins ties).
module mem_arbiter #(
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] inst_addr,
    input  logic        inst_req,
    output logic        inst_ack,
    output logic [31:0] inst_q,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_data,
    input  logic        data_wren,
    input  logic [3:0]  data_mask,
    input  logic        data_req,
    output logic        data_ack,
    output logic [31:0] data_q,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data,
    output logic        mem_wren,
    output logic [3:0]  mem_mask,
    output logic        mem_req,
    input  logic        mem_ack,
    input  logic [31:0] mem_q,
    output logic        bus_error,
    output logic [1:0]  dbg_state
);

    // Handshake: a requester holds req and a stable payload until it sees a one-cycle ack;
    // the memory side sees mem_req high for the whole grant and answers with a one-cycle mem_ack.
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] GNT_INST = 2'd1;
    localparam logic [1:0] GNT_DATA = 2'd2;

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [CW-1:0] cnt;
    logic          granted;
    logic          expire;
    logic          pick_data;
    logic [31:0]   addr_r;
    logic [31:0]   data_r;
    logic          wren_r;
    logic [3:0]    mask_r;

    assign granted = (state != IDLE);
    assign expire  = granted && (TIMEOUT > 0) && (cnt == LIMIT);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_data;

    // On a tie, the side that did not win last time goes next; reset favours data first.
    assign pick_data = data_req && (!inst_req || !last_data);

    always_ff @(posedge clk) begin
        if (reset) begin
            last_data <= 1'b0;
        end else if (state == IDLE && (inst_req || data_req)) begin
            last_data <= pick_data;
        end
    end
`else
    assign pick_data = data_req;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (pick_data) begin
                    state_nxt = GNT_DATA;
                end else if (inst_req) begin
                    state_nxt = GNT_INST;
                end
            end
            GNT_INST, GNT_DATA: begin
                if (mem_ack || expire) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            addr_r <= '0;
            data_r <= '0;
            wren_r <= 1'b0;
            mask_r <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                cnt <= '0;
                if (state_nxt == GNT_DATA) begin
                    addr_r <= data_addr;
                    data_r <= data_data;
                    wren_r <= data_wren;
                    mask_r <= data_mask;
                end else if (state_nxt == GNT_INST) begin
                    addr_r <= inst_addr;
                    data_r <= '0;
                    wren_r <= 1'b0;
                    mask_r <= 4'hF;
                end
            end else if (!mem_ack && cnt != LIMIT) begin
                // Saturates at LIMIT so a disabled timeout never wraps.
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign mem_req   = granted;
    assign mem_addr  = addr_r;
    assign mem_data  = data_r;
    assign mem_mask  = mask_r;
    assign mem_wren  = (state == GNT_DATA) && wren_r;

    // A transaction caught by reset is abandoned silently.
    assign inst_ack  = (state == GNT_INST) && (mem_ack || expire) && !reset;
    assign data_ack  = (state == GNT_DATA) && (mem_ack || expire) && !reset;
    assign inst_q    = ((state == GNT_INST) && mem_ack && !reset) ? mem_q : 32'h0;
    assign data_q    = ((state == GNT_DATA) && mem_ack && !reset) ? mem_q : 32'h0;
    assign bus_error = expire && !mem_ack && !reset;
    assign dbg_state = state;

endmodule
